// File: rtl/multi_alarm_controller.sv
// Multi-channel alarm clock: binary HH:MM:SS timekeeping, per-channel ring/snooze FSMs, registered BCD display.
// Build option: define MULTI_ALARM_SNOOZE_EN to add the SNOOZED state, snooze counters and i_Snooze handling.
module multi_alarm_controller #(
  parameter int ALARM_NUM        = 4,
  parameter int SNOOZE_MIN       = 9,
  parameter int RING_TIMEOUT_MIN = 10,
  parameter int HOUR_24          = 0,
  parameter int START_HOURS      = 0,
  parameter int START_MINUTES    = 0,
  localparam int SEL_W = (ALARM_NUM > 1) ? $clog2(ALARM_NUM) : 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_Sec_Pulse,
  input  logic [1:0]           i_Mode,
  input  logic [SEL_W-1:0]     i_Alarm_Sel,
  input  logic                 i_Minutes_Inc,
  input  logic                 i_Hours_Inc,
  input  logic                 i_Alarm_Enable_Toggle,
  input  logic                 i_Snooze,
  input  logic                 i_Dismiss,
  output logic [23:0]          o_Display_Time,
  output logic                 o_Display_PM,
  output logic [ALARM_NUM-1:0] o_Alarm_Enabled,
  output logic [ALARM_NUM-1:0] o_Alarm_Ringing,
  output logic                 o_Alarm_Any
);

`ifdef MULTI_ALARM_SNOOZE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1, SNOOZED = 2'd2} alarm_state_t;
  localparam logic [5:0] SNOOZE_LOAD = 6'(SNOOZE_MIN);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1} alarm_state_t;
`endif

  function automatic logic [7:0] bcd2(input logic [5:0] v);
    logic [3:0] t;
    logic [5:0] r;
    t = 4'd0;
    r = v;
    for (int k = 0; k < 5; k++) begin
      if (r >= 6'd10) begin
        r = r - 6'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  // Returns {pm, hour_bcd} for the configured display format.
  function automatic logic [8:0] fmt_hour(input logic [4:0] h);
    if (HOUR_24 != 0) return {1'b0, bcd2({1'b0, h})};
    if (h == 5'd0)    return {1'b0, 8'h12};
    if (h < 5'd12)    return {1'b0, bcd2({1'b0, h})};
    if (h == 5'd12)   return {1'b1, 8'h12};
    return {1'b1, bcd2({1'b0, 5'(h - 5'd12)})};
  endfunction

  localparam logic [4:0]  RST_H        = 5'(START_HOURS);
  localparam logic [5:0]  RST_M        = 6'(START_MINUTES);
  localparam logic [8:0]  RST_HF       = fmt_hour(RST_H);
  localparam logic [23:0] RST_DISP     = {RST_HF[7:0], bcd2(RST_M), 8'h00};
  localparam logic [5:0]  TIMEOUT_LAST = 6'(RING_TIMEOUT_MIN - 1);

  logic [4:0] hrs, hrs_n;
  logic [5:0] mins, mins_n, secs, secs_n;
  logic       set_time, set_alarm, rollover, sel_ok;
  logic [ALARM_NUM-1:0] sel_hit, en, en_n;
  logic [4:0]   al_h   [ALARM_NUM];
  logic [4:0]   al_h_n [ALARM_NUM];
  logic [5:0]   al_m   [ALARM_NUM];
  logic [5:0]   al_m_n [ALARM_NUM];
  logic [5:0]   ring_t   [ALARM_NUM];
  logic [5:0]   ring_t_n [ALARM_NUM];
  alarm_state_t st   [ALARM_NUM];
  alarm_state_t st_n [ALARM_NUM];
`ifdef MULTI_ALARM_SNOOZE_EN
  logic [5:0]   snz_c   [ALARM_NUM];
  logic [5:0]   snz_c_n [ALARM_NUM];
`else
  logic         unused_snooze;
  assign unused_snooze = i_Snooze ^ (SNOOZE_MIN == 0);
`endif

  assign set_time  = (i_Mode == 2'd1);
  assign set_alarm = (i_Mode == 2'd2);
  assign rollover  = !set_time && i_Sec_Pulse && (secs == 6'd59);
  assign sel_ok    = (32'(i_Alarm_Sel) < ALARM_NUM);

  always_comb begin
    sel_hit = '0;
    if (sel_ok) sel_hit[i_Alarm_Sel] = 1'b1;
  end

  always_comb begin
    hrs_n  = hrs;
    mins_n = mins;
    secs_n = secs;
    if (set_time) begin
      secs_n = 6'd0;
      if (i_Minutes_Inc) mins_n = (mins == 6'd59) ? 6'd0 : mins + 6'd1;
      if (i_Hours_Inc)   hrs_n  = (hrs == 5'd23) ? 5'd0 : hrs + 5'd1;
    end else if (i_Sec_Pulse) begin
      if (secs == 6'd59) begin
        secs_n = 6'd0;
        if (mins == 6'd59) begin
          mins_n = 6'd0;
          hrs_n  = (hrs == 5'd23) ? 5'd0 : hrs + 5'd1;
        end else begin
          mins_n = mins + 6'd1;
        end
      end else begin
        secs_n = secs + 6'd1;
      end
    end
  end

  // Per-channel next state: edits, enable toggle, then ring/snooze FSM; disabling overrides all.
  always_comb begin
    for (int i = 0; i < ALARM_NUM; i++) begin
      al_h_n[i]   = al_h[i];
      al_m_n[i]   = al_m[i];
      en_n[i]     = en[i];
      st_n[i]     = st[i];
      ring_t_n[i] = ring_t[i];
`ifdef MULTI_ALARM_SNOOZE_EN
      snz_c_n[i]  = snz_c[i];
`endif
      if (set_alarm && sel_hit[i]) begin
        if (i_Minutes_Inc) al_m_n[i] = (al_m[i] == 6'd59) ? 6'd0 : al_m[i] + 6'd1;
        if (i_Hours_Inc)   al_h_n[i] = (al_h[i] == 5'd23) ? 5'd0 : al_h[i] + 5'd1;
      end
      if (i_Alarm_Enable_Toggle && sel_hit[i]) en_n[i] = ~en[i];
      case (st[i])
        IDLE: begin
          if (rollover && en_n[i] && (al_h[i] == hrs_n) && (al_m[i] == mins_n)) begin
            st_n[i]     = RINGING;
            ring_t_n[i] = 6'd0;
          end
        end
        RINGING: begin
          if (i_Dismiss) begin
            st_n[i] = IDLE;
`ifdef MULTI_ALARM_SNOOZE_EN
          end else if (i_Snooze) begin
            st_n[i]    = SNOOZED;
            snz_c_n[i] = SNOOZE_LOAD;
`endif
          end else if (rollover) begin
            if (ring_t[i] == TIMEOUT_LAST) st_n[i] = IDLE;
            else ring_t_n[i] = ring_t[i] + 6'd1;
          end
        end
`ifdef MULTI_ALARM_SNOOZE_EN
        SNOOZED: begin
          if (i_Dismiss) begin
            st_n[i] = IDLE;
          end else if (rollover) begin
            if (snz_c[i] <= 6'd1) begin
              st_n[i]     = RINGING;
              ring_t_n[i] = 6'd0;
              snz_c_n[i]  = 6'd0;
            end else begin
              snz_c_n[i] = snz_c[i] - 6'd1;
            end
          end
        end
`endif
        default: st_n[i] = IDLE;
      endcase
      if (en[i] && !en_n[i]) st_n[i] = IDLE;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      hrs  <= RST_H;
      mins <= RST_M;
      secs <= 6'd0;
      en   <= '0;
      for (int i = 0; i < ALARM_NUM; i++) begin
        al_h[i]   <= 5'd0;
        al_m[i]   <= 6'd0;
        st[i]     <= IDLE;
        ring_t[i] <= 6'd0;
`ifdef MULTI_ALARM_SNOOZE_EN
        snz_c[i]  <= 6'd0;
`endif
      end
    end else begin
      hrs  <= hrs_n;
      mins <= mins_n;
      secs <= secs_n;
      en   <= en_n;
      for (int i = 0; i < ALARM_NUM; i++) begin
        al_h[i]   <= al_h_n[i];
        al_m[i]   <= al_m_n[i];
        st[i]     <= st_n[i];
        ring_t[i] <= ring_t_n[i];
`ifdef MULTI_ALARM_SNOOZE_EN
        snz_c[i]  <= snz_c_n[i];
`endif
      end
    end
  end

  logic [4:0]  show_h;
  logic [5:0]  show_m, show_s;
  logic [8:0]  hour_fmt;
  logic [23:0] disp_p1;
  logic        pm_p1;

  always_comb begin
    show_h = hrs;
    show_m = mins;
    show_s = secs;
    if (set_alarm && sel_ok) begin
      show_h = al_h[i_Alarm_Sel];
      show_m = al_m[i_Alarm_Sel];
      show_s = 6'd0;
    end
    hour_fmt = fmt_hour(show_h);
  end

  // Display stage: one register of BCD conversion behind the internal state.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      disp_p1 <= RST_DISP;
      pm_p1   <= RST_HF[8];
    end else begin
      disp_p1 <= {hour_fmt[7:0], bcd2(show_m), bcd2(show_s)};
      pm_p1   <= hour_fmt[8];
    end
  end

  always_comb begin
    for (int i = 0; i < ALARM_NUM; i++) o_Alarm_Ringing[i] = (st[i] == RINGING);
  end

  assign o_Alarm_Any     = |o_Alarm_Ringing;
  assign o_Alarm_Enabled = en;
  assign o_Display_Time  = disp_p1;
  assign o_Display_PM    = pm_p1;

endmodule

// File: tb/tb_multi_alarm_controller.sv
// Bench for multi_alarm_controller: seconds-of-day reference model checked every cycle plus literal spot checks.
module tb_multi_alarm_controller;
  localparam int N        = 4;
  localparam int SNOOZE   = 9;
  localparam int TIMEOUT  = 10;
  localparam int H24      = 0;
`ifdef MULTI_ALARM_SNOOZE_EN
  localparam bit SNZ_ON = 1'b1;
`else
  localparam bit SNZ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, sec, minc, hinc, tog, snz, dis;
  logic [1:0] mode, sel;
  logic [23:0] disp;
  logic pm, any;
  logic [N-1:0] en, ring;

  always #5 clk = ~clk;

  multi_alarm_controller #(
    .ALARM_NUM(N), .SNOOZE_MIN(SNOOZE), .RING_TIMEOUT_MIN(TIMEOUT),
    .HOUR_24(H24), .START_HOURS(7), .START_MINUTES(59)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Sec_Pulse(sec), .i_Mode(mode), .i_Alarm_Sel(sel),
    .i_Minutes_Inc(minc), .i_Hours_Inc(hinc), .i_Alarm_Enable_Toggle(tog),
    .i_Snooze(snz), .i_Dismiss(dis), .o_Display_Time(disp), .o_Display_PM(pm),
    .o_Alarm_Enabled(en), .o_Alarm_Ringing(ring), .o_Alarm_Any(any)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: time as seconds of day; ring timeout / snooze wake tracked against a global rollover count.
  int tsec, rolls;
  int ah[N], am[N], mst[N], start[N], wake[N];
  bit men[N];
  logic [23:0] e_disp;
  logic e_pm;

  function automatic logic [7:0] dd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [24:0] fmt(input int h, input int m, input int s);
    int hh;
    logic p;
    hh = h;
    p = 1'b0;
    if (H24 == 0) begin
      p = (h >= 12);
      hh = h % 12;
      if (hh == 0) hh = 12;
    end
    return {p, dd(hh), dd(m), dd(s)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    tsec = 7 * 3600 + 59 * 60;
    rolls = 0;
    for (int i = 0; i < N; i++) begin
      ah[i] = 0; am[i] = 0; mst[i] = 0; men[i] = 1'b0; start[i] = 0; wake[i] = 0;
    end
    {e_pm, e_disp} = fmt(7, 59, 0);
  endtask

  task automatic model_step();
    int h, m, s, nh, nm;
    bit roll, old_en;
    logic [24:0] f;
    h = tsec / 3600; m = (tsec / 60) % 60; s = tsec % 60;
    if (mode == 2'd2) f = fmt(ah[sel], am[sel], 0);
    else f = fmt(h, m, s);
    e_pm = f[24];
    e_disp = f[23:0];
    roll = 1'b0;
    if (mode == 2'd1) begin
      if (minc) m = (m + 1) % 60;
      if (hinc) h = (h + 1) % 24;
      tsec = h * 3600 + m * 60;
    end else if (sec) begin
      roll = (s == 59);
      tsec = (tsec + 1) % 86400;
    end
    if (roll) rolls++;
    nh = tsec / 3600; nm = (tsec / 60) % 60;
    for (int i = 0; i < N; i++) begin
      old_en = men[i];
      if (tog && sel == i) men[i] = !men[i];
      case (mst[i])
        0: if (roll && men[i] && ah[i] == nh && am[i] == nm) begin mst[i] = 1; start[i] = rolls; end
        1: begin
          if (dis) mst[i] = 0;
          else if (snz && SNZ_ON) begin mst[i] = 2; wake[i] = rolls + SNOOZE; end
          else if (roll && (rolls - start[i]) == TIMEOUT) mst[i] = 0;
        end
        default: begin
          if (dis) mst[i] = 0;
          else if (roll && rolls == wake[i]) begin mst[i] = 1; start[i] = rolls; end
        end
      endcase
      if (old_en && !men[i]) mst[i] = 0;
      if (mode == 2'd2 && sel == i) begin
        if (minc) am[i] = (am[i] + 1) % 60;
        if (hinc) ah[i] = (ah[i] + 1) % 24;
      end
    end
  endtask

  function automatic logic [N-1:0] e_ring();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (mst[i] == 1);
    return r;
  endfunction

  function automatic logic [N-1:0] e_en();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = men[i];
    return r;
  endfunction

  initial forever begin
    @(negedge clk);
    if (chk_en && !rst) begin
      check("disp", 32'(disp), 32'(e_disp));
      check("pm", 32'(pm), 32'(e_pm));
      check("enabled", 32'(en), 32'(e_en()));
      check("ringing", 32'(ring), 32'(e_ring()));
      check("any", 32'(any), 32'(|e_ring()));
    end
  end

  task automatic clk1();
    @(posedge clk);
    model_step();
    #2;
    sec = 0; minc = 0; hinc = 0; tog = 0; snz = 0; dis = 0;
  endtask

  task automatic secs(input int n);
    repeat (n) begin sec = 1; clk1(); end
  endtask

  task automatic incs(input int nh, input int nm);
    repeat (nh) begin hinc = 1; clk1(); end
    repeat (nm) begin minc = 1; clk1(); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; sec = 0; minc = 0; hinc = 0; tog = 0; snz = 0; dis = 0; mode = 2'd0; sel = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst = 0;
    chk_en = 1'b1;
    check("rst_disp", 32'(disp), 32'h075900);
    check("rst_pm", 32'(pm), 32'd0);
    check("rst_ring", 32'(ring), 32'd0);
    check("rst_en", 32'(en), 32'd0);

    secs(60); clk1();
    check("t0800", 32'(disp), 32'h080000);

    secs(5);
    mode = 2'd1; clk1();
    incs(15, 60);
    clk1();
    check("min_wrap", 32'(disp), 32'h110000);
    check("min_wrap_pm", 32'(pm), 32'd1);
    incs(0, 59);
    secs(3); clk1();
    check("set_hold", 32'(disp), 32'h115900);
    mode = 2'd0; clk1();
    check("exit_set", 32'(disp), 32'h115900);
    secs(60); clk1();
    check("midnight", 32'(disp), 32'h120000);
    check("midnight_pm", 32'(pm), 32'd0);

    mode = 2'd1; incs(13, 5); clk1();
    check("pm_fmt", 32'(disp), 32'h010500);
    check("pm_flag", 32'(pm), 32'd1);

    mode = 2'd2; sel = 2'd2; incs(6, 30);
    tog = 1; clk1(); clk1();
    check("al_disp", 32'(disp), 32'h063000);
    check("al_en", 32'(en), 32'b0100);
    sel = 2'd1; incs(6, 30);
    mode = 2'd1; incs(17, 24);
    mode = 2'd0; sel = 2'd0; clk1();
    secs(59);
    check("pre_ring", 32'(ring), 32'd0);
    secs(1);
    check("ring_hit", 32'(ring), 32'b0100);
    check("ring_any", 32'(any), 32'd1);

    secs(599);
    check("ring_9min", 32'(ring), 32'b0100);
    secs(1);
    check("timeout", 32'(ring), 32'd0);

    mode = 2'd2; sel = 2'd2; incs(0, 11);
    mode = 2'd0; clk1();
    secs(60);
    check("ring2", 32'(ring), 32'b0100);
    tog = 1; clk1();
    check("dis_ring", 32'(ring), 32'd0);
    check("dis_en", 32'(en), 32'd0);
    tog = 1; clk1();
    check("reen", 32'(en), 32'b0100);

    mode = 2'd2; incs(0, 1);
    mode = 2'd0; clk1();
    secs(60);
    check("ring3", 32'(ring), 32'b0100);
`ifdef MULTI_ALARM_SNOOZE_EN
    snz = 1; clk1();
    check("snoozed", 32'(ring), 32'd0);
    secs(539);
    check("snz_wait", 32'(ring), 32'd0);
    secs(1);
    check("rering", 32'(ring), 32'b0100);
    snz = 1; dis = 1; clk1();
    check("snz_dis", 32'(ring), 32'd0);
    secs(600);
    check("stay_idle", 32'(ring), 32'd0);
`else
    snz = 1; clk1();
    check("snz_ign", 32'(ring), 32'b0100);
    dis = 1; clk1();
    check("dismiss", 32'(ring), 32'd0);
`endif
    clk1();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_alarm_controller.md
Name: multi_alarm_controller

Overview:
Parametrised successor to the single-alarm clock datapath. Holds a running HH:MM:SS time plus ALARM_NUM independently enabled alarms, each with its own ring/snooze state machine. Provides time-set and alarm-set modes, a display mux and a 12/24-hour output format. Sits between the debounced/pulsed button logic and the seven-segment driver, clocked from the 5 MHz domain.

Parameters:
ALARM_NUM, 4, number of alarm channels (1..8)
SNOOZE_MIN, 9, minutes a snoozed alarm waits before re-ringing (1..59)
RING_TIMEOUT_MIN, 10, minutes an unattended alarm rings before auto-dismiss (1..59)
HOUR_24, 0, 1 = 24-hour display, 0 = 12-hour display with PM flag
START_HOURS, 0, time hours after reset (0..23)
START_MINUTES, 0, time minutes after reset (0..59)

Ports:
i_Clk  in  1  system clock (5 MHz)
i_Reset  in  1  asynchronous, active-high reset
i_Sec_Pulse  in  1  one-cycle pulse, once per second
i_Mode  in  2  0 = run, 1 = set time, 2 = set alarm, 3 = run
i_Alarm_Sel  in  $clog2(ALARM_NUM) (min 1)  alarm channel addressed in set-alarm mode and shown on display
i_Minutes_Inc  in  1  one-cycle increment pulse
i_Hours_Inc  in  1  one-cycle increment pulse
i_Alarm_Enable_Toggle  in  1  one-cycle pulse; toggles enable of channel i_Alarm_Sel
i_Snooze  in  1  one-cycle pulse
i_Dismiss  in  1  one-cycle pulse
o_Display_Time  out  24  BCD HH:MM:SS, time or selected alarm
o_Display_PM  out  1  PM flag for the displayed value (0 when HOUR_24=1)
o_Alarm_Enabled  out  ALARM_NUM  per-channel enable
o_Alarm_Ringing  out  ALARM_NUM  per-channel ringing
o_Alarm_Any  out  1  OR of o_Alarm_Ringing

Behaviour:
- Reset: time = START_HOURS:START_MINUTES:00; all alarms 00:00, disabled, IDLE; o_Alarm_Ringing = 0, o_Alarm_Any = 0; display shows reset time.
- Internal storage is binary (h 0-23, m 0-59, s 0-59). BCD conversion is registered, so display lags internal state by exactly 1 cycle.
- Run (mode 0/3): on i_Sec_Pulse, s increments; 59→0 carries to m; m 59→0 carries to h; h 23→0. "Minute rollover" = the cycle s wraps 59→0.
- Set time (mode 1): counting halted, s forced to 0. i_Minutes_Inc: m+1, 59→0, no carry to h. i_Hours_Inc: h+1, 23→0. Leaving mode 1 resumes counting from s=0.
- Set alarm (mode 2): time keeps running; inc pulses edit channel i_Alarm_Sel with the same wrap rules; display shows that alarm, seconds = 00.
- i_Alarm_Enable_Toggle works in any mode. i_Alarm_Sel ≥ ALARM_NUM is ignored for edits and toggles; display then shows time.
- Match: in run or set-alarm mode, on a minute rollover, each enabled IDLE channel whose h:m equals the new time h:m goes RINGING on the next cycle. No match in set-time mode.
- Per-channel FSM: IDLE → RINGING (match). RINGING → IDLE (i_Dismiss, or RING_TIMEOUT_MIN minute rollovers elapsed). RINGING → SNOOZED (i_Snooze; load snooze count = SNOOZE_MIN). SNOOZED: count decrements on each minute rollover; at 0 → RINGING with ring timer cleared. SNOOZED → IDLE on i_Dismiss.
- i_Snooze/i_Dismiss act on every channel currently in the relevant state. Snooze and dismiss in the same cycle: dismiss wins.
- Disabling a channel (toggle) in RINGING or SNOOZED forces IDLE that cycle. Editing an alarm's time leaves its FSM state unchanged.
- Match and re-ring in the same cycle on one channel: RINGING (single entry, timer cleared).
- 12-hour format: h 0→12 AM, 1-11 AM, 12→12 PM, 13-23 → 1-11 PM. 24-hour format: h unchanged, PM=0.
- Reset mid-ring or mid-snooze returns everything to the reset values immediately (asynchronous).

Optional Feature:
MULTI_ALARM_SNOOZE_EN: defined → SNOOZED state, snooze counters and i_Snooze behave as above. Undefined → no SNOOZED state or counters; i_Snooze ignored; RINGING leaves only via dismiss, timeout or disable.

Test Plan:
- Reset with START 7:59 → display 07:59:00, PM=0; 60 i_Sec_Pulse → 08:00:00.
- Time 23:59:59, one i_Sec_Pulse → 00:00:00; 12-hour display 12:00:00 AM; time 13:05 → 01:05, PM=1.
- Alarm 2 = 06:30 enabled, time 06:29:59, one pulse → o_Alarm_Ringing = 0100 next cycle; alarm 1 at 06:30 but disabled does not ring.
- Ringing, i_Snooze → ringing clears; 9 minute rollovers → rings again; i_Snooze+i_Dismiss together → IDLE (snooze macro defined).
- Ringing unattended → auto IDLE exactly at the 10th minute rollover; toggle-disable while ringing → IDLE next cycle.
- Set time mode: minutes inc at 59 → 00 with hours unchanged; no match while in mode 1; seconds read 00 on exit.
